// File: rtl/edge_capture_sequencer.sv
// Sequencer around a rising-edge detector: gates its reset, windows a capture run and
// timestamps each edge into a small FIFO. Holdoff after each edge exists only with EDGE_CAPTURE_HOLDOFF_EN.
module edge_capture_sequencer #(
    parameter int TS_W       = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] window_len,
    input  logic [CNT_W-1:0] holdoff_len,
    input  logic [CNT_W-1:0] max_events,
    input  logic             edge_in,
    output logic             det_reset,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] event_count,
    output logic             overflow,
    output logic [TS_W-1:0]  ts_data,
    output logic             ts_valid,
    input  logic             ts_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_FINISH  = 3'd4;
`ifdef EDGE_CAPTURE_HOLDOFF_EN
    localparam logic [2:0] S_HOLDOFF = 3'd3;
`endif

    logic [2:0]       state_q, state_d;
    logic [TS_W-1:0]  ts_cnt_q;
    logic [CNT_W-1:0] win_len_q, max_ev_q;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] event_count_q, event_count_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;

    logic [TS_W-1:0]  fifoMem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

    logic             startAcc, inWindow, capture, expired, maxHit;
    logic             fifoEmpty, fifoFull, push, pop;
    logic [CNT_W-1:0] countInc;

`ifdef EDGE_CAPTURE_HOLDOFF_EN
    logic [CNT_W-1:0] hold_len_q;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    assign inWindow = (state_q == S_RUN) || (state_q == S_HOLDOFF);
`else
    logic unused_holdoff;
    assign unused_holdoff = ^holdoff_len;
    assign inWindow = (state_q == S_RUN);
`endif

    assign startAcc  = start && (state_q == S_IDLE);
    assign capture   = edge_in && (state_q == S_RUN);
    assign expired   = inWindow && (win_len_q != '0) && (win_cnt_q == win_len_q);
    assign countInc  = (&event_count_q) ? event_count_q : event_count_q + CNT_W'(1);
    assign maxHit    = capture && (max_ev_q != '0) && (countInc == max_ev_q);

    // Extra pointer bit distinguishes full from empty; a pop frees the slot for a same-cycle push.
    assign fifoEmpty = (wr_ptr_q == rd_ptr_q);
    assign fifoFull  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop       = !fifoEmpty && ts_ready;
    assign push      = capture && (!fifoFull || pop);

    always_comb begin
        state_d       = state_q;
        win_cnt_d     = win_cnt_q;
        event_count_d = event_count_q;
        timeout_d     = timeout_q;
        overflow_d    = overflow_q;
`ifdef EDGE_CAPTURE_HOLDOFF_EN
        hold_cnt_d    = hold_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_CLEAR;
                    win_cnt_d     = '0;
                    event_count_d = '0;
                    timeout_d     = 1'b0;
                    overflow_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = stop ? S_FINISH : S_RUN;
            end
            S_RUN: begin
                win_cnt_d = win_cnt_q + CNT_W'(1);
                if (capture) begin
                    event_count_d = countInc;
                    if (fifoFull && !pop) overflow_d = 1'b1;
                end
                // Reaching max_events or an explicit stop beats window expiry for the timeout flag.
                if (maxHit || stop) begin
                    state_d = S_FINISH;
                end else if (expired) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
`ifdef EDGE_CAPTURE_HOLDOFF_EN
                end else if (capture && (hold_len_q != '0)) begin
                    state_d    = S_HOLDOFF;
                    hold_cnt_d = CNT_W'(1);
`endif
                end
            end
`ifdef EDGE_CAPTURE_HOLDOFF_EN
            S_HOLDOFF: begin
                win_cnt_d = win_cnt_q + CNT_W'(1);
                if (stop) begin
                    state_d = S_FINISH;
                end else if (expired) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end else if (hold_cnt_q == hold_len_q) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
`endif
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ts_cnt_q      <= '0;
            win_len_q     <= '0;
            max_ev_q      <= '0;
            win_cnt_q     <= '0;
            event_count_q <= '0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            ts_cnt_q      <= ts_cnt_q + TS_W'(1);
            win_cnt_q     <= win_cnt_d;
            event_count_q <= event_count_d;
            timeout_q     <= timeout_d;
            overflow_q    <= overflow_d;
            if (startAcc) begin
                win_len_q <= window_len;
                max_ev_q  <= max_events;
            end
            if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

`ifdef EDGE_CAPTURE_HOLDOFF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_len_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            if (startAcc) hold_len_q <= holdoff_len;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push) fifoMem[wr_ptr_q[PTR_W-1:0]] <= ts_cnt_q;
    end

    assign det_reset   = !inWindow;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign timeout     = timeout_q;
    assign event_count = event_count_q;
    assign overflow    = overflow_q;
    assign ts_valid    = !fifoEmpty;
    assign ts_data     = fifoEmpty ? '0 : fifoMem[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_edge_capture_sequencer.sv
// Testbench for edge_capture_sequencer: table-driven runs, hand-written corner cases and
// randomized runs checked against a run-level model of captures plus a queue model of the FIFO.
module tb_edge_capture_sequencer;

    localparam int TS_W  = 32;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4;
`ifdef EDGE_CAPTURE_HOLDOFF_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] window_len = '0;
    logic [CNT_W-1:0] holdoff_len = '0;
    logic [CNT_W-1:0] max_events = '0;
    logic             edge_in = 1'b0;
    logic             ts_ready = 1'b0;
    logic             det_reset, busy, done, timeout, overflow, ts_valid;
    logic [CNT_W-1:0] event_count;
    logic [TS_W-1:0]  ts_data;

    int compared = 0;
    int mismatched = 0;

    logic [TS_W-1:0] tbCycle;
    logic [TS_W-1:0] fifoModel[$];
    int              mdlCount;
    int              mdlTimeout;
    int              mdlTerm;
    bit              mdlCap[64];

    typedef struct {
        string       name;
        int          w;
        int          h;
        int          m;
        logic [31:0] edges;
        int          stopAt;
        logic [31:0] ready;
        bit          drain;
        int          expCount;
        int          expTimeout;
        int          expDoneOff;
    } vec_t;

    vec_t vecs[10];

    edge_capture_sequencer #(.TS_W(TS_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .window_len(window_len), .holdoff_len(holdoff_len), .max_events(max_events),
        .edge_in(edge_in), .det_reset(det_reset), .busy(busy), .done(done),
        .timeout(timeout), .event_count(event_count), .overflow(overflow),
        .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready)
    );

    always #5 clk = ~clk;

    // Independent cycle count since reset release; equals the expected free-running timestamp.
    always @(posedge clk or posedge reset) begin
        if (reset) tbCycle <= '0;
        else       tbCycle <= tbCycle + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Run-level reference: which RUN offsets capture, how the run ends and when.
    task automatic buildModel(input int w, input int h, input int m, input logic [31:0] edges, input int stopAt);
        int  nextAllowed;
        int  heff;
        bit  e;
        bit  hitMax;
        nextAllowed = 0;
        heff = HOLD_EN ? h : 0;
        mdlCount = 0;
        mdlTimeout = 0;
        mdlTerm = -1;
        for (int k = 0; k < 64; k++) mdlCap[k] = 1'b0;
        for (int k = 0; k < 64; k++) begin
            e = (k < 32) ? edges[k] : 1'b0;
            hitMax = 1'b0;
            if (e && k >= nextAllowed) begin
                mdlCap[k] = 1'b1;
                mdlCount++;
                hitMax = (m != 0) && (mdlCount == m);
                nextAllowed = k + heff + 1;
            end
            if (hitMax || k == stopAt) begin
                mdlTerm = k;
                break;
            end
            if (w != 0 && k == w) begin
                mdlTerm = k;
                mdlTimeout = 1;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input int w, input int h, input int m,
                                 input logic [31:0] edges, input int stopAt, input logic [31:0] readyMask,
                                 input bit drain, input int expCount, input int expTimeout, input int expDoneOff);
        logic [TS_W-1:0] run0;
        bit              expOvf;
        bit              sawDone;
        int              doneOff;
        expOvf = 1'b0;
        sawDone = 1'b0;
        doneOff = -1;
        buildModel(w, h, m, edges, stopAt);
        window_len = CNT_W'(w);
        holdoff_len = CNT_W'(h);
        max_events = CNT_W'(m);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, ".clear_busy"}, busy, 1);
        checkOutput({tag, ".clear_det_reset"}, det_reset, 1);
        checkOutput({tag, ".clear_overflow"}, overflow, 0);
        tick();
        checkOutput({tag, ".run_det_reset"}, det_reset, 0);
        run0 = tbCycle;
        for (int k = 0; k < 80; k++) begin
            edge_in = (k < 32) ? edges[k] : 1'b0;
            stop = (k == stopAt);
            ts_ready = (k < 32) ? readyMask[k] : 1'b0;
            if (ts_ready && fifoModel.size() > 0) begin
                checkOutput({tag, ".run_ts_valid"}, ts_valid, 1);
                checkOutput({tag, ".run_ts_data"}, ts_data, fifoModel[0]);
                void'(fifoModel.pop_front());
            end
            if (mdlCap[k]) begin
                if (fifoModel.size() < DEPTH) fifoModel.push_back(run0 + TS_W'(k));
                else expOvf = 1'b1;
            end
            tick();
            if (done === 1'b1) begin
                sawDone = 1'b1;
                doneOff = k + 1;
                break;
            end
        end
        edge_in = 1'b0;
        stop = 1'b0;
        ts_ready = 1'b0;
        checkOutput({tag, ".done_seen"}, sawDone, 1);
        checkOutput({tag, ".done_offset"}, doneOff, expDoneOff);
        checkOutput({tag, ".finish_det_reset"}, det_reset, 1);
        checkOutput({tag, ".timeout"}, timeout, expTimeout);
        checkOutput({tag, ".event_count"}, event_count, expCount);
        checkOutput({tag, ".overflow"}, overflow, expOvf);
        tick();
        checkOutput({tag, ".idle_busy"}, busy, 0);
        checkOutput({tag, ".idle_done"}, done, 0);
        if (drain) begin
            ts_ready = 1'b1;
            for (int i = 0; i < DEPTH + 1 && fifoModel.size() > 0; i++) begin
                checkOutput({tag, ".drain_ts_valid"}, ts_valid, 1);
                checkOutput({tag, ".drain_ts_data"}, ts_data, fifoModel[0]);
                void'(fifoModel.pop_front());
                tick();
            end
            ts_ready = 1'b0;
            checkOutput({tag, ".drained_ts_valid"}, ts_valid, 0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".det_reset"}, det_reset, 1);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".done"}, done, 0);
        checkOutput({tag, ".timeout"}, timeout, 0);
        checkOutput({tag, ".overflow"}, overflow, 0);
        checkOutput({tag, ".ts_valid"}, ts_valid, 0);
        checkOutput({tag, ".event_count"}, event_count, 0);
        checkOutput({tag, ".ts_data"}, ts_data, 0);
    endtask

    initial begin
        int w, h, m, stopAt;
        logic [31:0] edges, ready;

        vecs[0] = '{"window10", 10, 0, 0, 32'h24, -1, 32'h0, 1'b1, 2, 1, 11};
        vecs[1] = '{"max3", 0, 0, 3, 32'hFFFFFFFF, -1, 32'h0, 1'b1, 3, 0, 3};
        vecs[2] = '{"holdoff4", 0, 4, 0, 32'h3FF, 12, 32'h0, 1'b1, HOLD_EN ? 2 : 10, 0, 13};
        vecs[3] = '{"overflow6", 0, 0, 0, 32'h3F, 7, 32'h0, 1'b1, 6, 0, 8};
        vecs[4] = '{"stop_edge", 0, 0, 0, 32'h8, 3, 32'h0, 1'b1, 1, 0, 4};
        vecs[5] = '{"edge_expiry", 5, 0, 0, 32'h20, -1, 32'h0, 1'b1, 1, 1, 6};
        vecs[6] = '{"edge_expiry_max", 5, 0, 1, 32'h20, -1, 32'h0, 1'b1, 1, 0, 6};
        vecs[7] = '{"full_push_pop", 0, 0, 0, 32'h1F, 6, 32'h10, 1'b1, 5, 0, 7};
        vecs[8] = '{"stale_a", 0, 0, 0, 32'h3, 3, 32'h0, 1'b0, 2, 0, 4};
        vecs[9] = '{"stale_b", 0, 0, 0, 32'h6, 4, 32'h0, 1'b1, 2, 0, 5};

        #1 reset = 1'b1;
        tick();
        tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            $display("[TB] vector %s", vecs[i].name);
            applyStimulus(vecs[i].name, vecs[i].w, vecs[i].h, vecs[i].m, vecs[i].edges, vecs[i].stopAt,
                          vecs[i].ready, vecs[i].drain, vecs[i].expCount, vecs[i].expTimeout, vecs[i].expDoneOff);
        end

        // Reset lands two cycles after an edge with holdoff 4 (inside HOLDOFF when it is built).
        $display("[TB] reset during holdoff");
        window_len = '0;
        holdoff_len = CNT_W'(4);
        max_events = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        edge_in = 1'b1;
        tick();
        edge_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checkResetValues("midreset");
        reset = 1'b0;
        fifoModel.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midreset.no_done", done, 0);
            checkOutput("midreset.idle", busy, 0);
        end
        applyStimulus("after_reset", vecs[0].w, vecs[0].h, vecs[0].m, vecs[0].edges, vecs[0].stopAt,
                      vecs[0].ready, 1'b1, vecs[0].expCount, vecs[0].expTimeout, vecs[0].expDoneOff);

        for (int r = 0; r < 20; r++) begin
            w = $urandom_range(25, 1);
            h = $urandom_range(5, 0);
            m = $urandom_range(6, 0);
            edges = $urandom;
            ready = $urandom;
            stopAt = ($urandom_range(3, 0) == 0) ? $urandom_range(30, 0) : -1;
            buildModel(w, h, m, edges, stopAt);
            applyStimulus($sformatf("rand%0d", r), w, h, m, edges, stopAt, ready, 1'b1,
                          mdlCount, mdlTimeout, mdlTerm + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/edge_capture_sequencer.md
# edge_capture_sequencer

Sequencer that owns the rising-edge detector in the sampling path. It gates the detector's reset, opens a capture window on command, and timestamps each detected edge from a free-running counter. It limits event count and applies holdoff, and buffers timestamps in a small FIFO for a downstream consumer. It sits between the detector's `rising_edge_detected` output and the readout logic.

## Interface
- `TS_W`, 32, timestamp/free-running counter width
- `CNT_W`, 16, width of window, holdoff, max-event and event counters
- `FIFO_DEPTH`, 4, timestamp FIFO entries; power of two, ≥2

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; begins a capture run (ignored while `busy`)
- `stop`  in  1  one-cycle pulse; aborts a run (ignored while idle)
- `window_len`  in  CNT_W  run length in cycles; 0 = unlimited; sampled on accepted `start`
- `holdoff_len`  in  CNT_W  dead cycles after each edge; sampled on accepted `start`
- `max_events`  in  CNT_W  events ending the run; 0 = unlimited; sampled on accepted `start`
- `edge_in`  in  1  from detector `rising_edge_detected`
- `det_reset`  out  1  drives detector `reset`; high = detector held cleared
- `busy`  out  1  high from accepted `start` until return to IDLE
- `done`  out  1  one-cycle pulse at run end
- `timeout`  out  1  run ended by window expiry; valid from `done`, held until next `start`
- `event_count`  out  CNT_W  edges counted this run; saturates at all-ones
- `overflow`  out  1  sticky; edge seen with FIFO full; cleared on accepted `start`
- `ts_data`  out  TS_W  FIFO head timestamp
- `ts_valid`  out  1  FIFO non-empty
- `ts_ready`  in  1  consumer pops head when `ts_valid && ts_ready`

## Operation
- Free-running `ts_cnt` counts from 0 after reset and wraps modulo 2^TS_W. It runs regardless of state.
- IDLE: `det_reset`=1 and `busy`=0. An accepted `start` latches the config and clears `event_count`, `timeout` and `overflow`. Next state is CLEAR.
- CLEAR: one cycle with `det_reset`=1 so the detector flushes its history. Next state is RUN.
- RUN: `det_reset`=0. The window counter advances each cycle. When `edge_in`=1:
  - push `ts_cnt` of that cycle into the FIFO, or set `overflow` if full;
  - increment `event_count`;
  - if the new count equals `max_events` (≠0), go to FINISH; else if `holdoff_len`≠0, go to HOLDOFF; else stay in RUN.
- HOLDOFF: `det_reset`=0 and `edge_in` is ignored. The holdoff counter returns to RUN after `holdoff_len` cycles. The window counter keeps advancing.
- Window expiry: occurs when the count of cycles spent in RUN+HOLDOFF reaches `window_len` (≠0). The state goes to FINISH with `timeout`=1.
- Edge and expiry in the same cycle: the edge is captured. `timeout`=1 unless `max_events` was reached in that cycle.
- `stop` in CLEAR/RUN/HOLDOFF: go to FINISH with `timeout`=0. An edge in the same cycle is still captured.
- FINISH: one cycle with `done`=1 and `det_reset`=1. Next state is IDLE.
- FIFO: pop and push in the same cycle are both honoured when non-empty. With the FIFO full and a simultaneous pop, the push succeeds and `overflow` is not set. The FIFO is not cleared by `start`; stale entries drain normally.

## Timing
- Reset values: `det_reset`=1; `busy`, `done`, `timeout`, `overflow`, `ts_valid` all 0; `event_count`=0; `ts_data`=0. State is IDLE, `ts_cnt`=0 and the FIFO is empty.
- `start` at cycle T:
  - `busy`=1 at T+1 (CLEAR);
  - `det_reset` falls at T+2 (RUN).
- `edge_in` at cycle N in RUN:
  - `ts_valid`=1 and `event_count` updated at N+1;
  - `ts_data` equals `ts_cnt` at N.
- `done` pulses one cycle after the terminating event. `busy` falls in the cycle after `done`.
- Run length with `window_len`=W and no other terminator: `done` is asserted W+1 cycles after the first RUN cycle.
- `reset` mid-run: immediate return to IDLE with all outputs at reset values. No `done` pulse.

## Configuration
- `EDGE_CAPTURE_HOLDOFF_EN` defined: HOLDOFF state and holdoff counter are built as described.
- Not defined: `holdoff_len` is ignored, the HOLDOFF state is not built, and RUN continues after each edge. Every `edge_in` cycle in RUN is counted.

## Test plan
- `start` with W=10, holdoff=0, max=0, `edge_in` at RUN cycles 2 and 5 -> two FIFO entries with timestamps 3 cycles apart, `event_count`=2, `done` with `timeout`=1.
- max=3, W=0, `edge_in` held high -> exactly 3 events captured, `done` with `timeout`=0, FIFO holds 3 consecutive timestamps.
- holdoff=4 (macro defined), `edge_in` high 10 cycles -> events at RUN offsets 0 and 5, timestamps differ by 5. Macro undefined -> 10 events.
- `ts_ready`=0, 6 edges, DEPTH=4 -> 4 entries, `overflow`=1, `event_count`=6. Next `start` clears `overflow`.
- `stop` coincident with `edge_in` -> edge captured, `timeout`=0, `det_reset`=1 at FINISH.
- Assert `reset` during HOLDOFF -> all outputs at reset values next edge, no `done`. Subsequent `start` runs normally.
